fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL expose these parameters, one per line: name, default, meaning.
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- WAIT_LIMIT, 15, maximum cycles to wait for imem_ack before a fetch error.
REQ-002 The module SHALL expose these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on posedge clk.
- rst_n, in, 1, synchronous active-low reset.
- imem_req, out, 1, instruction-memory read request.
- imem_addr, out, 32, word-aligned fetch address.
- imem_ack, in, 1, read data valid this cycle.
- imem_rdata, in, 32, instruction word.
- instr, out, 32, held instruction.
- opcode, out, 6, instr[31:26]; drives the main control decoder's Instruction input.
- instr_valid, out, 1, instr holds a fetched, unconsumed instruction.
- instr_ready, in, 1, downstream consumes instr this cycle.
- Jump, in, 1, control Jump for the current instr.
- Branch, in, 1, control Branch for the current instr.
- Zero, in, 1, ALU zero flag for the current instr.
- pc, out, 32, address of the current instr.
- pc_plus4, out, 32, pc + 4.
- fetch_err, out, 1, sticky memory-timeout flag.

Function
REQ-003 The FSM SHALL have exactly three states: FETCH, VALID and ERR.
REQ-004 FETCH SHALL drive imem_req=1 and imem_addr=pc, and SHALL hold both stable until imem_ack or timeout.
REQ-005 In FETCH, imem_ack=1 SHALL capture imem_rdata into instr, set instr_valid=1 on the next cycle, and move to VALID.
REQ-006 A wait counter SHALL clear on entry to FETCH and increment on each FETCH cycle with imem_ack=0.
REQ-007 When the wait counter reaches WAIT_LIMIT with imem_ack=0, the FSM SHALL move to ERR, set fetch_err=1 and drop imem_req.
REQ-008 If imem_ack=1 arrives in the same cycle the limit is reached, the ack SHALL win and no error SHALL be raised.
REQ-009 VALID SHALL drive imem_req=0 and hold instr, pc and instr_valid=1 until instr_ready=1.
REQ-010 In VALID with instr_ready=1, pc SHALL load next_pc, instr_valid SHALL clear, and the FSM SHALL return to FETCH, so one idle cycle separates fetches.
REQ-011 next_pc priority SHALL be:
- Jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
- else Branch&Zero=1: pc_plus4 + (sign-extended instr[15:0] << 2).
- else: pc_plus4.
REQ-012 Jump, Branch and Zero SHALL be ignored when instr_valid=0 or instr_ready=0.
REQ-013 All PC arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC + 4 wraps to 0.
REQ-014 pc[1:0] and imem_addr[1:0] SHALL always be 2'b00.
REQ-015 ERR SHALL be absorbing: imem_req=0, instr_valid=0, fetch_err=1 until reset.
REQ-016 instr_ready while instr_valid=0 SHALL have no effect.

Reset
REQ-017 With rst_n=0 at a clock edge, the block SHALL set pc=RESET_PC, instr=0, instr_valid=0, fetch_err=0, wait counter=0 and state=FETCH.
REQ-018 Reset SHALL take priority over every other event, including mid-fetch acks and consumption.
REQ-019 imem_req SHALL assert in the first cycle after rst_n rises, with imem_addr=RESET_PC.

Structure
REQ-020 The state encoding, the RESET_PC default and the opcode field bounds [31:26] SHALL reside in the shared package mips_pkg.
REQ-021 The next_pc computation SHALL be a combinational sub-module named pc_next.
REQ-022 There SHALL be no other sub-modules.

Verification
REQ-023 Reset fetch: release rst_n, ack after 2 cycles with rdata=32'h2008_0005 -> imem_addr=0; instr_valid=1 with opcode=6'h08; pc=0.
REQ-024 Sequential fetch: consume with no Jump/Branch -> next imem_addr=4; next consume -> imem_addr=8.
REQ-025 Taken branch: pc=32'h10, instr=32'h1000_FFFC, Branch=1, Zero=1, consume -> next imem_addr=32'h4.
REQ-026 Not-taken branch: same instruction with Zero=0 -> next imem_addr=32'h14.
REQ-027 Jump: pc=32'h10, instr=32'h0800_0040, Jump=1, Branch=1, Zero=1 -> next imem_addr=32'h100.
REQ-028 Timeout and boundary cases:
- No ack for 15 cycles -> fetch_err=1, imem_req=0, fetch_err persists.
- Ack on cycle 15 -> no error.
- rst_n=0 mid-FETCH -> pc=RESET_PC and fetch_err cleared.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: datapath widths, opcode field bounds,
// fetch FSM encoding and reset defaults.
package mips_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned IMM16_W    = 16;
    localparam int unsigned TARGET_W   = 26;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int unsigned     WAIT_LIMIT_DEFAULT = 15;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_VALID = 2'd1,
        S_ERR   = 2'd2
    } fetch_state_e;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and memory (slave).
interface fetch_unit_if;

    logic                       imem_req;
    logic [mips_pkg::XLEN-1:0]  imem_addr;
    logic                       imem_ack;
    logic [mips_pkg::XLEN-1:0]  imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pc_next.sv
// Next-PC selection: jump target, taken branch, or sequential.
module pc_next
    import mips_pkg::*;
(
    input  logic [XLEN-1:0]     pc_plus4,
    input  logic [TARGET_W-1:0] imm26,
    input  logic                jump,
    input  logic                branch,
    input  logic                zero,
    output logic [XLEN-1:0]     next_pc_c
);

    logic [XLEN-1:0] jump_target;
    logic [XLEN-1:0] branch_offset;
    logic [XLEN-1:0] branch_target;

    always_comb begin
        jump_target   = {pc_plus4[XLEN-1:XLEN-4], imm26, 2'b00};
        branch_offset = {{(XLEN-IMM16_W-2){imm26[IMM16_W-1]}}, imm26[IMM16_W-1:0], 2'b00};
        branch_target = pc_plus4 + branch_offset;

        next_pc_c = pc_plus4;
        if (jump) begin
            next_pc_c = jump_target;
        end else if (branch && zero) begin
            next_pc_c = branch_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: requests one word at pc, holds it until consumed, then
// advances pc by jump/branch/sequential rules; times out to a sticky error.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     WAIT_LIMIT = WAIT_LIMIT_DEFAULT
)(
    input  logic                clk,
    input  logic                rst_n,
    fetch_unit_if.master        imem,
    output logic [XLEN-1:0]     instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                Jump,
    input  logic                Branch,
    input  logic                Zero,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4,
    output logic                fetch_err
);

    localparam int unsigned     CNT_W            = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_LAST      = CNT_W'(WAIT_LIMIT - 1);
    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = word_align(RESET_PC);

    fetch_state_e     state, state_d;
    logic [XLEN-1:0]  pc_d, plus4_d, instr_d;
    logic             valid_d, err_d, req_q, req_d;
    logic [CNT_W-1:0] wait_cnt, cnt_d;
    logic [XLEN-1:0]  next_pc_c;

    pc_next u_pc_next (
        .pc_plus4  (pc_plus4),
        .imm26     (instr[TARGET_W-1:0]),
        .jump      (Jump),
        .branch    (Branch),
        .zero      (Zero),
        .next_pc_c (next_pc_c)
    );

    // State and datapath registers; reset wins over any concurrent event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC_ALIGNED;
            pc_plus4    <= RESET_PC_ALIGNED + 32'd4;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            wait_cnt    <= '0;
            req_q       <= 1'b1;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            pc_plus4    <= plus4_d;
            instr       <= instr_d;
            instr_valid <= valid_d;
            fetch_err   <= err_d;
            wait_cnt    <= cnt_d;
            req_q       <= req_d;
        end
    end

    // Next-state and next-register values.
    always_comb begin
        state_d = state;
        pc_d    = pc;
        plus4_d = pc_plus4;
        instr_d = instr;
        valid_d = instr_valid;
        err_d   = fetch_err;
        cnt_d   = wait_cnt;

        case (state)
            S_FETCH: begin
                // An ack on the final allowed cycle is accepted, not a timeout.
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    valid_d = 1'b1;
                    state_d = S_VALID;
                end else if (wait_cnt == LIMIT_LAST) begin
                    cnt_d   = wait_cnt + CNT_W'(1);
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d   = wait_cnt + CNT_W'(1);
                end
            end
            S_VALID: begin
                if (instr_ready) begin
                    pc_d    = word_align(next_pc_c);
                    plus4_d = pc_d + 32'd4;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_ERR: begin
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
            default: begin
                valid_d = 1'b0;
                err_d   = 1'b1;
                state_d = S_ERR;
            end
        endcase

        req_d = (state_d == S_FETCH);
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign opcode         = instr[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a transaction-level PC model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ready;
    logic        Jump, Branch, Zero;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .Jump        (Jump),
        .Branch      (Branch),
        .Zero        (Zero),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_err   (fetch_err)
    );

    int          vectors;
    int          miscompares;
    logic [31:0] pc_m;
    logic [31:0] cur_instr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Architectural next-PC rule.
    function automatic logic [31:0] model_next(input logic [31:0] cpc, input logic [31:0] ins,
                                               input logic j, input logic b, input logic z);
        logic [31:0] seq;
        logic [31:0] off;
        seq = cpc + 32'd4;
        off = {{16{ins[15]}}, ins[15:0]};
        if (j) return (seq & 32'hF000_0000) | ({6'b0, ins[25:0]} << 2);
        if (b && z) return seq + off * 32'd4;
        return seq;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        instr_ready = 1'b0;
        Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        pc_m = 32'h0;
    endtask

    // Memory answers after d idle FETCH cycles; checks address stability and capture.
    task automatic serve(input int d, input logic [31:0] data, input bit noise);
        for (int i = 0; i < d; i++) begin
            vectors++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== pc_m) begin
                miscompares++;
                $display("FAIL fetch_wait: req=%b addr=%h expected req=1 addr=%h", bus.imem_req, bus.imem_addr, pc_m);
            end
            bus.imem_ack = 1'b0;
            if (noise) begin
                instr_ready = 1'($urandom_range(0, 1));
                Jump = 1'($urandom_range(0, 1));
                Branch = 1'($urandom_range(0, 1));
                Zero = 1'($urandom_range(0, 1));
            end
            tick();
        end
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== pc_m || fetch_err !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_ack_cycle: req=%b addr=%h err=%b expected req=1 addr=%h err=0",
                     bus.imem_req, bus.imem_addr, fetch_err, pc_m);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = data;
        instr_ready = 1'b0;
        Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
        tick();
        bus.imem_ack = 1'b0;
        bus.imem_rdata = $urandom;
        cur_instr = data;
        vectors++;
        if (instr_valid !== 1'b1 || instr !== data || opcode !== data[31:26]) begin
            miscompares++;
            $display("FAIL capture: valid=%b instr=%h opcode=%h expected valid=1 instr=%h opcode=%h",
                     instr_valid, instr, opcode, data, data[31:26]);
        end
        vectors++;
        if (pc !== pc_m || pc_plus4 !== 32'(pc_m + 32'd4) || bus.imem_req !== 1'b0 || fetch_err !== 1'b0) begin
            miscompares++;
            $display("FAIL valid_state: pc=%h pc4=%h req=%b err=%b expected pc=%h pc4=%h req=0 err=0",
                     pc, pc_plus4, bus.imem_req, fetch_err, pc_m, 32'(pc_m + 32'd4));
        end
    endtask

    // Downstream holds off for 'hold' cycles, then consumes with the given controls.
    task automatic consume(input logic j, input logic b, input logic z, input int hold);
        for (int i = 0; i < hold; i++) begin
            instr_ready = 1'b0;
            Jump = 1'($urandom_range(0, 1));
            Branch = 1'($urandom_range(0, 1));
            Zero = 1'($urandom_range(0, 1));
            tick();
            vectors++;
            if (instr_valid !== 1'b1 || instr !== cur_instr || pc !== pc_m || bus.imem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL hold: valid=%b instr=%h pc=%h req=%b expected valid=1 instr=%h pc=%h req=0",
                         instr_valid, instr, pc, bus.imem_req, cur_instr, pc_m);
            end
        end
        instr_ready = 1'b1;
        Jump = j; Branch = b; Zero = z;
        tick();
        instr_ready = 1'b0;
        Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
        pc_m = model_next(pc_m, cur_instr, j, b, z);
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== pc_m || pc !== pc_m || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL next_pc: req=%b addr=%h pc=%h valid=%b expected req=1 addr=%h valid=0",
                     bus.imem_req, bus.imem_addr, pc, instr_valid, pc_m);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_req: req=%b addr=%h expected req=1 addr=00000000", bus.imem_req, bus.imem_addr);
        end
        vectors++;
        if (instr !== 32'h0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 || pc !== 32'h0 || pc_plus4 !== 32'h4) begin
            miscompares++;
            $display("FAIL reset_regs: instr=%h valid=%b err=%b pc=%h pc4=%h expected 0/0/0/0/4",
                     instr, instr_valid, fetch_err, pc, pc_plus4);
        end
    endtask

    task automatic test_reset_fetch();
        serve(2, 32'h2008_0005, 1'b0);
        vectors++;
        if (opcode !== 6'h08) begin
            miscompares++;
            $display("FAIL reset_fetch_opcode: got %h expected 08", opcode);
        end
    endtask

    task automatic test_sequential();
        consume(1'b0, 1'b0, 1'b0, 0);
        vectors++;
        if (bus.imem_addr !== 32'h4) begin
            miscompares++;
            $display("FAIL seq_addr4: got %h expected 00000004", bus.imem_addr);
        end
        serve(0, 32'h0000_0020, 1'b0);
        consume(1'b0, 1'b0, 1'b0, 1);
        vectors++;
        if (bus.imem_addr !== 32'h8) begin
            miscompares++;
            $display("FAIL seq_addr8: got %h expected 00000008", bus.imem_addr);
        end
    endtask

    task automatic goto_0x10();
        serve(0, 32'h0800_0004, 1'b0);
        consume(1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_branches_and_jump();
        goto_0x10();
        serve(1, 32'h1000_FFFC, 1'b0);
        consume(1'b0, 1'b1, 1'b1, 0);
        vectors++;
        if (bus.imem_addr !== 32'h4) begin
            miscompares++;
            $display("FAIL branch_taken: got %h expected 00000004", bus.imem_addr);
        end
        goto_0x10();
        serve(0, 32'h1000_FFFC, 1'b0);
        consume(1'b0, 1'b1, 1'b0, 0);
        vectors++;
        if (bus.imem_addr !== 32'h14) begin
            miscompares++;
            $display("FAIL branch_not_taken: got %h expected 00000014", bus.imem_addr);
        end
        serve(0, 32'h0800_0004, 1'b0);
        consume(1'b1, 1'b0, 1'b0, 0);
        serve(3, 32'h0800_0040, 1'b0);
        consume(1'b1, 1'b1, 1'b1, 2);
        vectors++;
        if (bus.imem_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL jump_priority: got %h expected 00000100", bus.imem_addr);
        end
    endtask

    task automatic test_wrap();
        serve(0, 32'h1000_FFBE, 1'b0);
        consume(1'b0, 1'b1, 1'b1, 0);
        vectors++;
        if (bus.imem_addr !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_branch: got %h expected fffffffc", bus.imem_addr);
        end
        serve(0, 32'h0000_0000, 1'b0);
        consume(1'b0, 1'b0, 1'b0, 0);
        vectors++;
        if (bus.imem_addr !== 32'h0 || pc !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_seq: addr=%h pc=%h expected 00000000", bus.imem_addr, pc);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic j, b, z;
            logic [31:0] data;
            data = $urandom;
            serve(int'($urandom_range(0, 14)), data, 1'b1);
            j = ($urandom_range(0, 3) == 0);
            b = 1'($urandom_range(0, 1));
            z = 1'($urandom_range(0, 1));
            consume(j, b, z, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_ack_on_limit();
        do_reset();
        serve(14, 32'hACED_0001, 1'b1);
        consume(1'b0, 1'b0, 1'b0, 0);
        vectors++;
        if (fetch_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_on_limit_err: got %b expected 0", fetch_err);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            bus.imem_ack = 1'b0;
            tick();
        end
        vectors++;
        if (bus.imem_req !== 1'b1 || fetch_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: req=%b err=%b expected req=1 err=0", bus.imem_req, fetch_err);
        end
        tick();
        vectors++;
        if (fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_err: err=%b req=%b valid=%b expected 1/0/0", fetch_err, bus.imem_req, instr_valid);
        end
        bus.imem_ack = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (fetch_err !== 1'b1 || bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL err_sticky: err=%b req=%b valid=%b expected 1/0/0", fetch_err, bus.imem_req, instr_valid);
            end
        end
        bus.imem_ack = 1'b0;
        instr_ready = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (fetch_err !== 1'b0 || bus.imem_req !== 1'b1 || pc !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_from_err: err=%b req=%b pc=%h expected 0/1/00000000", fetch_err, bus.imem_req, pc);
        end
        pc_m = 32'h0;
        serve(0, 32'h0800_0040, 1'b0);
        consume(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst_n = 1'b1;
        bus.imem_ack = 1'b0;
        pc_m = 32'h0;
        vectors++;
        if (pc !== 32'h0 || bus.imem_addr !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_fetch: pc=%h addr=%h instr=%h valid=%b err=%b expected all zero",
                     pc, bus.imem_addr, instr, instr_valid, fetch_err);
        end
        serve(0, 32'h0800_0040, 1'b0);
        rst_n = 1'b0;
        instr_ready = 1'b1;
        Jump = 1'b1;
        tick();
        rst_n = 1'b1;
        instr_ready = 1'b0;
        Jump = 1'b0;
        vectors++;
        if (pc !== 32'h0 || instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_over_consume: pc=%h valid=%b req=%b expected 00000000/0/1", pc, instr_valid, bus.imem_req);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_reset_fetch();
        test_sequential();
        test_branches_and_jump();
        test_wrap();
        test_random();
        test_ack_on_limit();
        test_timeout();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
